// File: rtl/prefix_sequencer_pkg.sv
// Shared decoder types and fixed instruction-set constants for the prefix sequencer.
// Opcode and modifier positions are measured from the word MSB.
package prefix_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StExt,
    StIdxWait,
    StIdx,
    StExtIdxWait,
    StExtIdx
  } seq_state_e;

  typedef enum logic [1:0] {
    RgnReg = 2'd0,
    RgnRam = 2'd1,
    RgnRom = 2'd2
  } region_e;

  localparam int unsigned ExtendWord = 'o00006;
  localparam int unsigned OpW        = 3;
  localparam logic [2:0]  OpIndex    = 3'd5;
  localparam int unsigned ModW       = 2;

endpackage

// File: rtl/oc_adder.sv
// Combinational adder: end-around carry (ones' complement) when ONES_COMP != 0,
// plain modular add otherwise.
module oc_adder #(
  parameter int unsigned WIDTH     = 15,
  parameter int unsigned ONES_COMP = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH:0] raw;

  always_comb begin
    raw = {1'b0, a} + {1'b0, b};
    sum = raw[WIDTH-1:0];
    // Folding the carry back in cannot carry out a second time.
    if (ONES_COMP != 0) begin
      sum = raw[WIDTH-1:0] + WIDTH'(raw[WIDTH]);
    end
  end

endmodule

// File: rtl/prefix_sequencer.sv
// Folds EXTEND / INDEX prefix words into the following instruction and emits one
// effective word per sequence through a single-entry output register.
module prefix_sequencer
  import prefix_sequencer_pkg::*;
#(
  parameter int unsigned WORD_W    = 15,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned ROM_BASE  = 'o2000,
  parameter int unsigned NREG      = 13,
  parameter int unsigned ONES_COMP = 1
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_instr,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic              idx_valid,
  input  logic [WORD_W-1:0] idx_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_instr,
  output logic              out_ext,
  output logic [1:0]        out_region,
  output logic [ADDR_W-1:0] out_pc,
  output logic              int_inhibit
);

  localparam logic [ADDR_W-1:0] NregAddr = ADDR_W'(NREG);
  localparam logic [ADDR_W-1:0] RomAddr  = ADDR_W'(ROM_BASE);

  function automatic region_e classify(logic [ADDR_W-1:0] addr);
    if (addr < NregAddr) return RgnReg;
    else if (addr < RomAddr) return RgnRam;
    else return RgnRom;
  endfunction

  seq_state_e        state_q, state_d;
  logic [WORD_W-1:0] index_sum_q, index_sum_d;
  logic              idx_add_q, idx_add_d;  // next INDEX operand accumulates
  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_instr_q, out_instr_d;
  logic              out_ext_q, out_ext_d;
  region_e           out_region_q, out_region_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;

  logic              wait_st, idx_st, ext_st, accept, emit;
  logic              is_extend, is_index_op, is_index;
  logic [WORD_W-1:0] add_a, add_sum, eff;

  // One adder serves both paths: word modification never coincides with a wait state.
  assign wait_st = (state_q == StIdxWait) || (state_q == StExtIdxWait);
  assign idx_st  = (state_q == StIdx) || (state_q == StExtIdx);
  assign ext_st  = (state_q == StExt) || (state_q == StExtIdx);
  assign add_a   = wait_st ? idx_data : in_instr;

  oc_adder #(
    .WIDTH     (WORD_W),
    .ONES_COMP (ONES_COMP)
  ) u_oc_adder (
    .a   (add_a),
    .b   (index_sum_q),
    .sum (add_sum)
  );

  assign eff         = idx_st ? add_sum : in_instr;
  assign accept      = in_valid && in_ready;
  assign is_extend   = (eff == WORD_W'(ExtendWord));
  assign is_index_op = (eff[WORD_W-1 -: OpW] == OpIndex);
  assign is_index    = is_index_op && (eff[WORD_W-1-OpW -: ModW] == '0);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      index_sum_q  <= '0;
      idx_add_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_ext_q    <= 1'b0;
      out_region_q <= RgnReg;
      out_pc_q     <= '0;
    end else begin
      state_q      <= state_d;
      index_sum_q  <= index_sum_d;
      idx_add_q    <= idx_add_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_ext_q    <= out_ext_d;
      out_region_q <= out_region_d;
      out_pc_q     <= out_pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    index_sum_d = index_sum_q;
    idx_add_d   = idx_add_q;
    emit        = 1'b0;
    if (flush) begin
      state_d     = StIdle;
      index_sum_d = '0;
      idx_add_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (is_extend) begin
              state_d = StExt;
            end else if (is_index) begin
              state_d   = StIdxWait;
              idx_add_d = 1'b0;
            end else begin
              emit = 1'b1;
            end
          end
        end
        StIdx: begin
          if (accept) begin
            if (is_index) begin
              state_d   = StIdxWait;
              idx_add_d = 1'b1;
            end else begin
              emit = 1'b1;
            end
          end
        end
        StExt: begin
          if (accept) begin
            if (is_index_op) begin
              state_d   = StExtIdxWait;
              idx_add_d = 1'b0;
            end else begin
              emit = 1'b1;
            end
          end
        end
        StExtIdx: begin
          if (accept) emit = 1'b1;
        end
        StIdxWait: begin
          if (idx_valid) begin
            index_sum_d = idx_add_q ? add_sum : idx_data;
            state_d     = StIdx;
          end
        end
        StExtIdxWait: begin
          if (idx_valid) begin
            index_sum_d = idx_data;
            state_d     = StExtIdx;
          end
        end
        default: state_d = StIdle;
      endcase
      if (emit) begin
        state_d     = StIdle;
        index_sum_d = '0;
        idx_add_d   = 1'b0;
      end
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q && !out_ready;
    out_instr_d  = out_instr_q;
    out_ext_d    = out_ext_q;
    out_region_d = out_region_q;
    out_pc_d     = out_pc_q;
    if (emit) begin
      out_valid_d  = 1'b1;
      out_instr_d  = eff;
      out_ext_d    = ext_st;
      out_region_d = classify(eff[ADDR_W-1:0]);
      out_pc_d     = in_pc;
    end
  end

  always_comb begin
    in_ready    = !rst && !wait_st && !flush && (!out_valid_q || out_ready);
    int_inhibit = (state_q != StIdle);
    out_valid   = out_valid_q;
    out_instr   = out_instr_q;
    out_ext     = out_ext_q;
    out_region  = out_region_q;
    out_pc      = out_pc_q;
  end

endmodule

// File: tb/tb_prefix_sequencer.sv
// Directed scenarios followed by randomized prefix sequences scored against a
// word-level model of EXTEND / INDEX folding.
module tb_prefix_sequencer;

  typedef struct {
    logic [14:0] instr;
    logic        ext;
    logic [1:0]  rgn;
    logic [11:0] pc;
  } exp_t;

  logic        clock, rst, in_valid, in_ready, idx_valid, flush;
  logic        out_valid, out_ready, out_ext, int_inhibit;
  logic [14:0] in_instr, idx_data, out_instr;
  logic [11:0] in_pc, out_pc;
  logic [1:0]  out_region;

  int          tests, fails;
  bit          mon_en, rnd_ready;
  logic [11:0] pc_ctr;
  exp_t        exp_q[$];

  prefix_sequencer dut (
    .clock       (clock),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .idx_valid   (idx_valid),
    .idx_data    (idx_data),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_ext     (out_ext),
    .out_region  (out_region),
    .out_pc      (out_pc),
    .int_inhibit (int_inhibit)
  );

  always #5 clock = ~clock;

  function automatic logic [14:0] oc_add(logic [14:0] a, logic [14:0] b);
    int unsigned s;
    s = int'(a) + int'(b);
    if (s >= 32768) s = s - 32768 + 1;
    return 15'(s);
  endfunction

  function automatic logic [1:0] region_of(logic [14:0] x);
    int unsigned a;
    a = int'(x) % 4096;
    if (a < 13) return 2'd0;
    if (a < 'o2000) return 2'd1;
    return 2'd2;
  endfunction

  function automatic bit is_idle_prefix(logic [14:0] x);
    return (x == 15'o6) || (x[14:12] == 3'd5 && x[11:10] == 2'b00);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [14:0] i, input logic e,
                           input logic [1:0] g, input logic [11:0] p);
    check({tag, "_valid"}, 32'(out_valid), 1);
    check({tag, "_instr"}, 32'(out_instr), 32'(i));
    check({tag, "_ext"}, 32'(out_ext), 32'(e));
    check({tag, "_region"}, 32'(out_region), 32'(g));
    check({tag, "_pc"}, 32'(out_pc), 32'(p));
  endtask

  // Called and returns at posedge+1.
  task automatic send(input logic [14:0] w);
    bit ok;
    ok       = 1'b0;
    in_instr = w;
    in_pc    = pc_ctr;
    in_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clock);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("in_ready_timeout", 32'(ok), 1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    pc_ctr++;
  endtask

  task automatic give_idx(input logic [14:0] d);
    idx_data  = d;
    idx_valid = 1'b1;
    @(posedge clock);
    #1;
    idx_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_out_instr"}, 32'(out_instr), 0);
    check({tag, "_out_ext"}, 32'(out_ext), 0);
    check({tag, "_out_region"}, 32'(out_region), 0);
    check({tag, "_out_pc"}, 32'(out_pc), 0);
    check({tag, "_int_inhibit"}, 32'(int_inhibit), 0);
    check({tag, "_in_ready"}, 32'(in_ready), 0);
  endtask

  initial begin
    logic [14:0] w, e, r, sum, d;
    logic [11:0] p;
    int          kind;
    bit          found;

    clock = 1'b0; rst = 1'b1; in_valid = 1'b0; idx_valid = 1'b0; flush = 1'b0;
    out_ready = 1'b1; in_instr = '0; in_pc = '0; idx_data = '0;
    tests = 0; fails = 0; mon_en = 1'b0; rnd_ready = 1'b0; pc_ctr = 12'o100;

    fork
      forever begin
        @(posedge clock);
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      end
      forever begin
        exp_t m;
        @(negedge clock);
        if (mon_en && out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", 32'(out_valid), 0);
          end else begin
            m = exp_q.pop_front();
            check("rnd_instr", 32'(out_instr), 32'(m.instr));
            check("rnd_ext", 32'(out_ext), 32'(m.ext));
            check("rnd_region", 32'(out_region), 32'(m.rgn));
            check("rnd_pc", 32'(out_pc), 32'(m.pc));
          end
        end
      end
    join_none

    #12;
    check_reset_outputs("reset");
    @(negedge clock);
    rst = 1'b0;
    @(posedge clock);
    #1;
    check("ready_after_reset", 32'(in_ready), 1);

    // EXTEND then ordinary word
    send(15'o6);
    check("ext_inhibit", 32'(int_inhibit), 1);
    check("ext_no_out", 32'(out_valid), 0);
    send(15'o10123);
    check_out("ext_word", 15'o10123, 1'b1, 2'd1, 12'(pc_ctr - 12'd1));

    // INDEX with one operand
    send(15'o50100);
    check("idxw_inhibit", 32'(int_inhibit), 1);
    check("idxw_ready", 32'(in_ready), 0);
    check("idxw_no_out", 32'(out_valid), 0);
    give_idx(15'o2);
    check("idx_inhibit", 32'(int_inhibit), 1);
    send(15'o30001);
    check_out("idx_word", 15'o30003, 1'b0, 2'd0, 12'(pc_ctr - 12'd1));
    check("idx_done_inhibit", 32'(int_inhibit), 0);

    // End-around carry
    send(15'o50000);
    give_idx(15'o77776);
    send(15'o3);
    check_out("eac_word", 15'o2, 1'b0, 2'd0, 12'(pc_ctr - 12'd1));

    // Stray idx_valid in IDLE has no effect
    give_idx(15'o5);
    send(15'o30001);
    check_out("stray_idx", 15'o30001, 1'b0, 2'd0, 12'(pc_ctr - 12'd1));

    // Back-pressure: held word stays, nothing accepted, nothing lost
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    send(15'o12345);
    check_out("bp_first", 15'o12345, 1'b0, 2'd2, 12'(pc_ctr - 12'd1));
    in_instr = 15'o23456;
    in_pc    = pc_ctr;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("bp_hold_valid", 32'(out_valid), 1);
      check("bp_hold_instr", 32'(out_instr), 32'(15'o12345));
      check("bp_hold_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    pc_ctr++;
    check_out("bp_second", 15'o23456, 1'b0, 2'd2, 12'(pc_ctr - 12'd1));

    // Flush leaves a pending output alone
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    send(15'o40017);
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    check("flush_keep_valid", 32'(out_valid), 1);
    check("flush_keep_instr", 32'(out_instr), 32'(15'o40017));
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    check("flush_drained", 32'(out_valid), 0);

    // Flush beats a same-cycle word after EXTEND
    send(15'o6);
    in_instr = 15'o10123;
    in_pc    = pc_ctr;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(negedge clock);
    check("flush_ready", 32'(in_ready), 0);
    @(posedge clock);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_inhibit", 32'(int_inhibit), 0);
    check("flush_no_out", 32'(out_valid), 0);
    send(15'o10123);
    check_out("after_flush", 15'o10123, 1'b0, 2'd1, 12'(pc_ctr - 12'd1));

    // Reset in IDX_WAIT
    @(posedge clock);
    #1;
    send(15'o50100);
    check("pre_rst_inhibit", 32'(int_inhibit), 1);
    rst = 1'b1;
    #2;
    check_reset_outputs("mid_rst");
    @(negedge clock);
    rst = 1'b0;
    @(posedge clock);
    #1;
    send(15'o30001);
    check_out("after_rst", 15'o30001, 1'b0, 2'd0, 12'(pc_ctr - 12'd1));

    // Randomized sequences with random back-pressure
    @(posedge clock);
    #1;
    mon_en    = 1'b1;
    rnd_ready = 1'b1;
    for (int g = 0; g < 120; g++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin
          do w = 15'($urandom); while (is_idle_prefix(w));
          p = pc_ctr;
          exp_q.push_back('{instr: w, ext: 1'b0, rgn: region_of(w), pc: p});
          send(w);
        end
        1: begin
          send(15'o6);
          do w = 15'($urandom); while (w[14:12] == 3'd5);
          if ($urandom_range(0, 7) == 0) w = 15'o6;
          p = pc_ctr;
          exp_q.push_back('{instr: w, ext: 1'b1, rgn: region_of(w), pc: p});
          send(w);
        end
        2: begin
          e = {3'd5, 2'b00, 10'($urandom)};
          send(e);
          d = 15'($urandom);
          give_idx(d);
          sum = d;
          if ($urandom_range(0, 1) == 1) begin
            found = 1'b0;
            for (int t = 0; t < 8 && !found; t++) begin
              e = {3'd5, 2'b00, 10'($urandom)};
              r = oc_add(e, ~sum);
              if (oc_add(r, sum) == e) found = 1'b1;
            end
            if (found) begin
              send(r);
              d = 15'($urandom);
              give_idx(d);
              sum = oc_add(sum, d);
            end
          end
          do begin
            w = 15'($urandom);
            e = oc_add(w, sum);
          end while (is_idle_prefix(e));
          p = pc_ctr;
          exp_q.push_back('{instr: e, ext: 1'b0, rgn: region_of(e), pc: p});
          send(w);
        end
        default: begin
          send(15'o6);
          send({3'd5, 12'($urandom)});
          d = 15'($urandom);
          give_idx(d);
          w = 15'($urandom);
          e = oc_add(w, d);
          p = pc_ctr;
          exp_q.push_back('{instr: e, ext: 1'b1, rgn: region_of(e), pc: p});
          send(w);
        end
      endcase
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (exp_q.size() == 0) break;
      @(posedge clock);
      #1;
    end
    @(posedge clock);
    #1;
    check("drain_left", 32'(exp_q.size()), 0);
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
